// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encoding,
// widths, latch-control bundle and a saturating-increment helper.
package pipe_ctrl_pkg;

   localparam int REG_W = 3;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      HALTED   = 2'b10
   } state_t;

   typedef struct packed {
      logic pc_en;
      logic f2d_en;
      logic d2e_en;
      logic e2m_en;
      logic m2w_en;
      logic f2d_flush;
      logic d2e_flush;
      logic e2m_flush;
      logic m2w_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN    = 9'b11111_0000;
   localparam ctrl_t CTRL_FREEZE = 9'b00000_0000;
   localparam ctrl_t CTRL_MEM    = 9'b00000_0001;
   localparam ctrl_t CTRL_BRANCH = 9'b11111_1100;
   // d2e is enabled so the injected bubble actually lands in execute
   localparam ctrl_t CTRL_LDUSE  = 9'b00111_0100;
   localparam ctrl_t CTRL_ISTALL = 9'b01111_1000;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dff.sv
// Generic register with synchronous active-high reset to a parameterised value.
module dff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Combinational load-use comparator; also used by the forwarding unit.
module pipe_ctrl_hazard
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] read_reg1,
   input  logic [REG_W-1:0] read_reg2,
   input  logic             read1_valid,
   input  logic             read2_valid,
   input  logic [REG_W-1:0] write_reg,
   input  logic             mem_read,
   input  logic             reg_wrt,
   output logic             load_use
);

   assign load_use = mem_read & reg_wrt &
                     ((read1_valid & (read_reg1 == write_reg)) |
                      (read2_valid & (read_reg2 == write_reg)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: owns PC/f2d/d2e/e2m/m2w enable and flush.
// Optional macro PIPE_CTRL_PERF_EN adds stallCnt/flushCnt perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] readReg1D,
   input  logic [REG_W-1:0] readReg2D,
   input  logic             read1ValidD,
   input  logic             read2ValidD,
   input  logic [REG_W-1:0] writeRegE,
   input  logic             memReadE,
   input  logic             regWrtE,
   input  logic             branchTakenE,
   input  logic             instStallF,
   input  logic             memStallM,
   input  logic             haltM,
   output logic             pcEn,
   output logic             f2dEn,
   output logic             d2eEn,
   output logic             e2mEn,
   output logic             m2wEn,
   output logic             f2dFlush,
   output logic             d2eFlush,
   output logic             e2mFlush,
   output logic             m2wFlush,
   output logic             haltedOut,
   output logic             errOut
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]       state_q, state_d;
   state_t           state, state_nxt;
   logic             load_use, halted, mem_stall;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             err_d;
   ctrl_t            ctrl;

   pipe_ctrl_hazard u_hazard (
      .read_reg1   (readReg1D),
      .read_reg2   (readReg2D),
      .read1_valid (read1ValidD),
      .read2_valid (read2ValidD),
      .write_reg   (writeRegE),
      .mem_read    (memReadE),
      .reg_wrt     (regWrtE),
      .load_use    (load_use)
   );

   assign state     = state_t'(state_q);
   assign halted    = (state == HALTED);
   // once halted every input is ignored, including the data-memory stall
   assign mem_stall = memStallM & ~halted;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN, MEM_WAIT: begin
            if (memStallM)  state_nxt = MEM_WAIT;
            else if (haltM) state_nxt = HALTED;
            else            state_nxt = RUN;
         end
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end
   assign state_d = state_nxt;

   dff #(.W(2), .RST_VAL(RUN)) u_state (.clk, .rst, .d(state_d), .q(state_q));

   always_comb begin
      ctrl = CTRL_RUN;
      if (rst)               ctrl = CTRL_RUN;
      else if (halted)       ctrl = CTRL_FREEZE;
      else if (memStallM)    ctrl = CTRL_MEM;
      else if (branchTakenE) ctrl = CTRL_BRANCH;
      else if (load_use)     ctrl = CTRL_LDUSE;
      else if (instStallF)   ctrl = CTRL_ISTALL;
   end

   assign {pcEn, f2dEn, d2eEn, e2mEn, m2wEn,
           f2dFlush, d2eFlush, e2mFlush, m2wFlush} = ctrl;

   // watchdog: run length of consecutive data-memory stalls, saturating
   assign wd_d  = mem_stall ? sat_inc(wd_q) : '0;
   assign err_d = errOut | (wd_d >= TIMEOUT);

   dff #(.W(CNT_W)) u_wd  (.clk, .rst, .d(wd_d),  .q(wd_q));
   dff #(.W(1))     u_err (.clk, .rst, .d(err_d), .q(errOut));

   assign haltedOut = halted;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_d, flush_d;
   logic             stall_inc, flush_inc;

   assign stall_inc = ~rst & ~halted & ~pcEn;
   assign flush_inc = ~halted & ~memStallM & branchTakenE;
   assign stall_d   = stall_inc ? sat_inc(stallCnt) : stallCnt;
   assign flush_d   = flush_inc ? sat_inc(flushCnt) : flushCnt;

   dff #(.W(CNT_W)) u_stall_cnt (.clk, .rst, .d(stall_d), .q(stallCnt));
   dff #(.W(CNT_W)) u_flush_cnt (.clk, .rst, .d(flush_d), .q(flushCnt));
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// against a cycle-level reference model (optional perf counters when PIPE_CTRL_PERF_EN).
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] readReg1D, readReg2D, writeRegE;
   logic       read1ValidD, read2ValidD, memReadE, regWrtE;
   logic       branchTakenE, instStallF, memStallM, haltM;
   logic       pcEn, f2dEn, d2eEn, e2mEn, m2wEn;
   logic       f2dFlush, d2eFlush, e2mFlush, m2wFlush;
   logic       haltedOut, errOut;
`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stallCnt, flushCnt;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_halted;
   bit m_err;
   int m_run;
   int m_stall_cnt;
   int m_flush_cnt;

   pipe_ctrl #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .readReg1D(readReg1D), .readReg2D(readReg2D),
      .read1ValidD(read1ValidD), .read2ValidD(read2ValidD),
      .writeRegE(writeRegE), .memReadE(memReadE), .regWrtE(regWrtE),
      .branchTakenE(branchTakenE), .instStallF(instStallF),
      .memStallM(memStallM), .haltM(haltM),
      .pcEn(pcEn), .f2dEn(f2dEn), .d2eEn(d2eEn), .e2mEn(e2mEn), .m2wEn(m2wEn),
      .f2dFlush(f2dFlush), .d2eFlush(d2eFlush), .e2mFlush(e2mFlush),
      .m2wFlush(m2wFlush), .haltedOut(haltedOut), .errOut(errOut)
`ifdef PIPE_CTRL_PERF_EN
      , .stallCnt(stallCnt), .flushCnt(flushCnt)
`endif
   );

   always #5 clk = ~clk;

   wire [8:0] ctrl = {pcEn, f2dEn, d2eEn, e2mEn, m2wEn,
                      f2dFlush, d2eFlush, e2mFlush, m2wFlush};

   function automatic bit model_load_use();
      return memReadE && regWrtE &&
             ((read1ValidD && readReg1D == writeRegE) ||
              (read2ValidD && readReg2D == writeRegE));
   endfunction

   // expected {pcEn,f2dEn,d2eEn,e2mEn,m2wEn,f2dFlush,d2eFlush,e2mFlush,m2wFlush}
   function automatic logic [8:0] model_ctrl();
      if (rst)               return 9'b11111_0000;
      if (m_halted)          return 9'b00000_0000;
      if (memStallM)         return 9'b00000_0001;
      if (branchTakenE)      return 9'b11111_1100;
      if (model_load_use())  return 9'b00111_0100;
      if (instStallF)        return 9'b01111_1000;
      return 9'b11111_0000;
   endfunction

   // advance one clock, updating the model from the inputs seen at the edge
   task automatic tick();
      logic [8:0] e;
      e = model_ctrl();
      @(posedge clk);
      if (rst) begin
         m_halted = 0; m_err = 0; m_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;
      end else if (!m_halted) begin
         if (!e[8]) m_stall_cnt++;
         if (branchTakenE && !memStallM) m_flush_cnt++;
         m_run = memStallM ? m_run + 1 : 0;
         if (m_run >= 64) m_err = 1;
         if (!memStallM && haltM) m_halted = 1;
      end
      #1;
   endtask

   task automatic idle();
      rst = 0; readReg1D = 0; readReg2D = 0; writeRegE = 0;
      read1ValidD = 0; read2ValidD = 0; memReadE = 0; regWrtE = 0;
      branchTakenE = 0; instStallF = 0; memStallM = 0; haltM = 0;
   endtask

   task automatic set_load_r3();
      memReadE = 1; regWrtE = 1; writeRegE = 3'd3;
      readReg1D = 3'd3; read1ValidD = 1; readReg2D = 3'd5; read2ValidD = 1;
   endtask

   task automatic do_reset();
      idle(); rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      idle(); rst = 1; memStallM = 1; haltM = 1;
      #4;
      checks++;
      if (ctrl !== 9'b11111_0000) begin
         errors++; $display("FAIL reset_ctrl_during_rst got=%b exp=%b", ctrl, 9'b11111_0000);
      end
      tick(); idle(); #4;
      checks++;
      if (ctrl !== 9'b11111_0000 || haltedOut !== 1'b0 || errOut !== 1'b0) begin
         errors++; $display("FAIL reset_state got ctrl=%b halted=%b err=%b exp ctrl=111110000 halted=0 err=0",
                            ctrl, haltedOut, errOut);
      end
      checks++;
      if (dut.state_q !== 2'b00) begin
         errors++; $display("FAIL reset_fsm got=%b exp=00", dut.state_q);
      end
      tick();
   endtask

   task automatic test_load_use();
      idle(); set_load_r3(); #4;
      checks++;
      if (ctrl !== 9'b00111_0100) begin
         errors++; $display("FAIL load_use_stall got=%b exp=%b", ctrl, 9'b00111_0100);
      end
      tick();
      memReadE = 0; regWrtE = 0; #4;
      checks++;
      if (ctrl !== 9'b11111_0000) begin
         errors++; $display("FAIL load_use_release got=%b exp=%b", ctrl, 9'b11111_0000);
      end
      tick();
      // second source matching, first not read
      idle(); set_load_r3(); read1ValidD = 0; readReg2D = 3'd3; #4;
      checks++;
      if (ctrl !== 9'b00111_0100) begin
         errors++; $display("FAIL load_use_src2 got=%b exp=%b", ctrl, 9'b00111_0100);
      end
      tick();
      idle(); set_load_r3(); instStallF = 1; #4;
      checks++;
      if (ctrl !== 9'b00111_0100) begin
         errors++; $display("FAIL load_use_over_istall got=%b exp=%b", ctrl, 9'b00111_0100);
      end
      tick(); idle();
   endtask

   task automatic test_no_use();
      idle(); set_load_r3(); read1ValidD = 0; #4;
      checks++;
      if (ctrl !== 9'b11111_0000) begin
         errors++; $display("FAIL no_use_invalid got=%b exp=%b", ctrl, 9'b11111_0000);
      end
      tick();
      set_load_r3(); regWrtE = 0; #4;
      checks++;
      if (ctrl !== 9'b11111_0000) begin
         errors++; $display("FAIL no_use_nowrite got=%b exp=%b", ctrl, 9'b11111_0000);
      end
      tick();
      idle(); instStallF = 1; #4;
      checks++;
      if (ctrl !== 9'b01111_1000) begin
         errors++; $display("FAIL istall got=%b exp=%b", ctrl, 9'b01111_1000);
      end
      tick(); idle();
   endtask

   task automatic test_branch();
      idle(); set_load_r3(); branchTakenE = 1; instStallF = 1; #4;
      checks++;
      if (ctrl !== 9'b11111_1100) begin
         errors++; $display("FAIL branch_over_load_use got=%b exp=%b", ctrl, 9'b11111_1100);
      end
      tick(); idle();
   endtask

   task automatic test_mem_stall();
      idle(); memStallM = 1; branchTakenE = 1; set_load_r3();
      for (int i = 0; i < 3; i++) begin
         #4;
         checks++;
         if (ctrl !== 9'b00000_0001) begin
            errors++; $display("FAIL mem_stall_cyc%0d got=%b exp=%b", i, ctrl, 9'b00000_0001);
         end
         checks++;
         if (dut.state_q !== ((i == 0) ? 2'b00 : 2'b01)) begin
            errors++; $display("FAIL mem_stall_state%0d got=%b exp=%b", i, dut.state_q,
                               (i == 0) ? 2'b00 : 2'b01);
         end
         tick();
      end
      idle(); #4;
      checks++;
      if (ctrl !== 9'b11111_0000 || dut.state_q !== 2'b01) begin
         errors++; $display("FAIL mem_stall_resume got=%b st=%b exp=111110000 st=01", ctrl, dut.state_q);
      end
      tick(); #4;
      checks++;
      if (dut.state_q !== 2'b00 || errOut !== 1'b0) begin
         errors++; $display("FAIL mem_stall_back_run got st=%b err=%b exp st=00 err=0", dut.state_q, errOut);
      end
      tick();
   endtask

   task automatic test_watchdog();
      idle(); memStallM = 1;
      for (int i = 0; i < 63; i++) tick();
      #4;
      checks++;
      if (errOut !== 1'b0) begin
         errors++; $display("FAIL watchdog_early got=%b exp=0", errOut);
      end
      tick(); #4;
      checks++;
      if (errOut !== 1'b1) begin
         errors++; $display("FAIL watchdog_set got=%b exp=1", errOut);
      end
      tick(); idle(); tick(); tick(); #4;
      checks++;
      if (errOut !== 1'b1 || ctrl !== 9'b11111_0000) begin
         errors++; $display("FAIL watchdog_sticky got err=%b ctrl=%b exp err=1 ctrl=111110000", errOut, ctrl);
      end
      tick(); do_reset(); #4;
      checks++;
      if (errOut !== 1'b0) begin
         errors++; $display("FAIL watchdog_clear got=%b exp=0", errOut);
      end
      tick();
   endtask

   task automatic test_halt();
      idle(); haltM = 1; #4;
      checks++;
      if (ctrl !== 9'b11111_0000 || haltedOut !== 1'b0) begin
         errors++; $display("FAIL halt_accept got ctrl=%b halted=%b exp ctrl=111110000 halted=0", ctrl, haltedOut);
      end
      tick();
      idle(); branchTakenE = 1; memStallM = 1; set_load_r3();
      for (int i = 0; i < 3; i++) begin
         #4;
         checks++;
         if (ctrl !== 9'b00000_0000 || haltedOut !== 1'b1) begin
            errors++; $display("FAIL halted_cyc%0d got ctrl=%b halted=%b exp ctrl=000000000 halted=1",
                               i, ctrl, haltedOut);
         end
         tick();
      end
      do_reset(); #4;
      checks++;
      if (haltedOut !== 1'b0 || dut.state_q !== 2'b00 || ctrl !== 9'b11111_0000) begin
         errors++; $display("FAIL halt_reset got halted=%b st=%b ctrl=%b exp halted=0 st=00 ctrl=111110000",
                            haltedOut, dut.state_q, ctrl);
      end
      tick();
   endtask

   task automatic test_random();
      logic [8:0] e;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst          = ($urandom_range(0, 99) < 3);
         readReg1D    = 3'($urandom);
         readReg2D    = 3'($urandom);
         writeRegE    = 3'($urandom);
         read1ValidD  = ($urandom_range(0, 99) < 70);
         read2ValidD  = ($urandom_range(0, 99) < 50);
         memReadE     = ($urandom_range(0, 99) < 50);
         regWrtE      = ($urandom_range(0, 99) < 70);
         branchTakenE = ($urandom_range(0, 99) < 20);
         instStallF   = ($urandom_range(0, 99) < 25);
         memStallM    = ($urandom_range(0, 99) < 25);
         haltM        = ($urandom_range(0, 99) < 4);
         #4;
         e = model_ctrl();
         checks++;
         if (ctrl !== e || haltedOut !== m_halted || errOut !== m_err) begin
            errors++;
            $display("FAIL random_cyc%0d got ctrl=%b halted=%b err=%b exp ctrl=%b halted=%b err=%b",
                     n, ctrl, haltedOut, errOut, e, m_halted, m_err);
         end
`ifdef PIPE_CTRL_PERF_EN
         checks++;
         if (stallCnt !== 16'(m_stall_cnt) || flushCnt !== 16'(m_flush_cnt)) begin
            errors++;
            $display("FAIL random_perf%0d got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                     n, stallCnt, flushCnt, m_stall_cnt, m_flush_cnt);
         end
`endif
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      m_halted = 0; m_err = 0; m_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;
      #1;
      test_reset();
      test_load_use();
      test_no_use();
      test_branch();
      test_mem_stall();
      test_watchdog();
      test_halt();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
